// File: rtl/snn_pkg.sv
// Shared definitions for the SNN input stage: encoder FSM states, default
// geometry constants and the Galois LFSR used by the stochastic encoder.
package snn_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } enc_state_t;

   localparam int DEF_NUM_CHANNELS = 8;
   localparam int DEF_PIX_W        = 8;
   localparam int DEF_STEP_W       = 8;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Right-shifting Galois step: the bit shifted out folds the taps back in.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      lfsr_next = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

endpackage

// File: rtl/spike_lfsr16.sv
// 16-bit Galois LFSR with synchronous reload to its seed; one per channel
// in the stochastic encoder build.
module spike_lfsr16
   import snn_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        load,
   input  logic        enable,
   output logic [15:0] lfsr_state
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lfsr_state <= SEED;
      end else if (load) begin
         lfsr_state <= SEED;
      end else if (enable) begin
         lfsr_state <= lfsr_next(lfsr_state);
      end
   end

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate-coding spike source for the first neuron layer. Deterministic
// accumulator mode by default; define ENCODER_LFSR_EN for stochastic mode.
module spike_rate_encoder
   import snn_pkg::*;
#(
   parameter int          NUM_CHANNELS = DEF_NUM_CHANNELS,
   parameter int          PIX_W        = DEF_PIX_W,
   parameter int          STEP_W       = DEF_STEP_W,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          pix_valid,
   output logic                          pix_ready,
   input  logic [NUM_CHANNELS*PIX_W-1:0] pix_data,
   input  logic [STEP_W-1:0]             num_steps,
   input  logic                          step_en,
   output logic [NUM_CHANNELS-1:0]       spike_out,
   output logic                          spike_valid,
   output logic                          busy,
   output logic                          done
);

   enc_state_t                    state, state_nxt;
   logic                          ready_en;
   logic [NUM_CHANNELS*PIX_W-1:0] pix_q;
   logic [STEP_W-1:0]             steps_left;
   logic [NUM_CHANNELS-1:0]       spike_q;
   logic [NUM_CHANNELS-1:0]       spike_calc;
   logic                          valid_q;
   logic                          accept;
   logic                          do_step;

   assign accept  = pix_valid && pix_ready;
   assign do_step = (state == RUN) && step_en && (steps_left != '0);

   // RUN lingers one cycle after the final step so done follows the last
   // spike_valid instead of coinciding with it.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = (num_steps == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (steps_left == '0) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         ready_en   <= 1'b0;
         pix_q      <= '0;
         steps_left <= '0;
         spike_q    <= '0;
         valid_q    <= 1'b0;
      end else begin
         state    <= state_nxt;
         ready_en <= 1'b1;
         valid_q  <= do_step;
         spike_q  <= do_step ? spike_calc : '0;
         if (accept) begin
            pix_q      <= pix_data;
            steps_left <= num_steps;
         end else if (do_step) begin
            steps_left <= steps_left - 1'b1;
         end
      end
   end

   genvar i;
   generate
      for (i = 0; i < NUM_CHANNELS; i++) begin : g_chan
`ifdef ENCODER_LFSR_EN
         logic [15:0] lfsr_state;

         spike_lfsr16 #(
            .SEED(LFSR_SEED ^ (16'(i) << 8))
         ) u_lfsr (
            .clk       (clk),
            .reset_n   (reset_n),
            .load      (accept),
            .enable    (do_step),
            .lfsr_state(lfsr_state)
         );

         assign spike_calc[i] = pix_q[i*PIX_W +: PIX_W] > lfsr_state[15 -: PIX_W];
`else
         logic [PIX_W-1:0] acc;
         logic [PIX_W:0]   sum;

         // Carry out of the running sum is the spike; the remainder carries over.
         assign sum           = {1'b0, acc} + {1'b0, pix_q[i*PIX_W +: PIX_W]};
         assign spike_calc[i] = sum[PIX_W];

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               acc <= '0;
            end else if (accept) begin
               acc <= '0;
            end else if (do_step) begin
               acc <= sum[PIX_W-1:0];
            end
         end
`endif
      end
   endgenerate

   assign pix_ready   = (state == IDLE) && ready_en;
   assign busy        = (state != IDLE);
   assign done        = (state == DONE);
   assign spike_valid = valid_q;
   assign spike_out   = valid_q ? spike_q : '0;

endmodule
